alu_mc_core: RTL and testbench
==============================

Name: alu_mc_core

Overview:
Parametrised, multi-cycle successor to the single-cycle integer/logic ALU. It accepts one operation per valid/ready handshake and keeps a carry/flag register, so ADC/SBB chain across operations. MUL runs as an iterative shift-add engine. It holds a small resettable scratch memory for LOAD/STORE. It sits between the decode stage and the register-file writeback, and results are returned through an output valid/ready handshake.

Parameters:
WIDTH, 32, operand width in bits (>=8); result bus is 2*WIDTH.
AW, 5, scratch-memory address width; DEPTH = 2**AW words of WIDTH bits.

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operation request valid
in_ready  output  1  block can accept an operation
opcode  input  5  operation code (table below)
rg1  input  WIDTH  operand A / store data
rg2  input  WIDTH  operand B
address  input  AW  scratch-memory word address
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out  output  2*WIDTH  result
flags  output  4  {C,Z,N,V}, registered
illegal  output  1  qualifies out_valid; unsupported opcode
busy  output  1  state != IDLE

Behaviour:
- Opcodes: ADD 00000, ADC 00001, SUB 00010, SBB 00011, MUL 00100, AND 01000, OR 01001, XOR 01010, NAND 01011, NOR 01100, XNOR 01101, NOT 01110, NEG 01111, LOAD 10000, STORE 11000. All others are illegal, including the FP codes 00101-00111.
- FSM states: IDLE, MUL, DONE. in_ready=1 only in IDLE. Accept = in_valid & in_ready; operands, opcode and address are captured at accept.
- Non-MUL op: the result is registered at accept and the FSM goes to DONE. out_valid rises the next cycle (latency 1).
- MUL: unsigned shift-add, one partial product per cycle, WIDTH cycles in MUL, then DONE. out_valid rises WIDTH+1 cycles after accept.
- DONE: out, flags and illegal stay stable while out_valid=1 and out_ready=0. When out_valid & out_ready, the FSM returns to IDLE. Accept is next possible the following cycle. There is no bypass.
- Arithmetic (results zero-extended to 2*WIDTH):
  - ADD: out = {C_out, rg1+rg2}.
  - ADC: adds the stored C.
  - SUB: rg1 + ~rg2 + 1.
  - SBB: rg1 + ~rg2 + stored C (C=1 means no borrow).
  - NEG: ~rg1 + 1; carry = 1 iff rg1 == 0.
  - MUL: full 2*WIDTH product.
- Logic ops and NOT: WIDTH-bit result, upper bits zero.
- Flags, updated when the result is registered:
  - Z: result[WIDTH-1:0] == 0; for MUL, the whole product == 0.
  - N: bit WIDTH-1; for MUL, bit 2*WIDTH-1.
  - C: carry out for ADD/ADC/SUB/SBB/NEG; cleared for logic ops and MUL.
  - V: signed overflow for ADD/ADC/SUB/SBB/NEG; cleared otherwise.
  - LOAD, STORE and illegal opcodes leave flags unchanged.
- LOAD: out = mem[address], zero-extended.
- STORE: mem[address] <= rg1 at accept; out = 0 for the response. A LOAD accepted after a STORE to the same address returns the new data.
- Illegal opcode: out = 0, illegal = 1, one-cycle latency, flags unchanged.
- Reset (asynchronous, any state, including mid-MUL or while holding DONE):
  - FSM goes to IDLE and any in-flight operation is dropped.
  - Outputs: out=0, out_valid=0, illegal=0, flags=0, busy=0; in_ready=1 after reset release.
  - Memory: mem[i] = i for all i.
- Operand inputs are don't-care outside accept.

Optional Feature:
Macro ALU_MC_SAT_EN.
- Defined: ADD/ADC/SUB/SBB/NEG saturate on signed overflow. The result clamps to 2^(WIDTH-1)-1 (positive overflow) or -2^(WIDTH-1) (negative), the out[WIDTH] carry bit is 0, and V=1 still reports the overflow.
- Undefined: results wrap modulo 2^WIDTH and the saturation logic is absent.

Test Plan:
- Reset, then LOAD address 7 -> out=7, flags=0, out_valid one cycle after accept.
- ADD 0xFFFFFFFF+0x00000001 -> out=0x1_00000000, C=1, Z=1. Then ADC 5+3 -> out=9, C=0.
- MUL 0x0001_0000 x 0x0003_0000 -> out=0x0000_0003_0000_0000, out_valid exactly 33 cycles after accept. Pulse rst_n low at cycle 10 of a second MUL -> out_valid never rises, in_ready=1 after release.
- Hold out_ready=0 for 5 cycles after SUB 3-5 -> out[31:0]=0xFFFFFFFE is stable, N=1, C=0, in_ready=0. Drive out_ready=1 -> return to IDLE.
- STORE 0xDEADBEEF to address 31, then LOAD 31 -> 0xDEADBEEF. Opcode 00101 -> illegal=1, out=0, flags unchanged.
- With ALU_MC_SAT_EN, ADD 0x7FFFFFFF+1 -> out=0x7FFFFFFF, V=1. Without it -> out=0x80000000, V=1.

Source files
------------

// File: rtl/alu_mc_core.sv
// ---------------------------------------------------------------------------
// alu_mc_core
//
// Multi-cycle integer/logic ALU placed between decode and register-file
// writeback. It takes one operation per in_valid/in_ready handshake and
// returns one result per out_valid/out_ready handshake. A {C,Z,N,V} flag
// register carries state between operations, so ADC/SBB chain across them.
// MUL is an iterative unsigned shift-add engine that adds one partial
// product per cycle. A small scratch memory serves LOAD/STORE; on reset it
// is initialised so that word i holds the value i.
//
// Optional feature macro: ALU_MC_SAT_EN
//   defined   : ADD/ADC/SUB/SBB/NEG clamp to the signed range on overflow
//               (out[WIDTH] = 0, V still reports the overflow)
//   undefined : arithmetic wraps modulo 2**WIDTH, no clamping logic
//
// Parameters
//   WIDTH : operand width in bits (>= 8); the result bus is 2*WIDTH wide
//   AW    : scratch-memory address width; the memory has 2**AW words
//
// Ports
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   in_valid  in   operation request valid
//   in_ready  out  high only in IDLE; accept = in_valid & in_ready
//   opcode    in   5-bit operation code
//   rg1       in   operand A / store data
//   rg2       in   operand B
//   address   in   scratch-memory word address
//   out_valid out  result valid (held until out_ready)
//   out_ready in   consumer accepts the result
//   out       out  2*WIDTH result, zero-extended
//   flags     out  {C,Z,N,V}, registered
//   illegal   out  qualifies out_valid: the opcode was unsupported
//   busy      out  FSM is not in IDLE
// ---------------------------------------------------------------------------
module alu_mc_core #(
  parameter int WIDTH = 32,
  parameter int AW    = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4:0]           opcode,
  input  logic [WIDTH-1:0]     rg1,
  input  logic [WIDTH-1:0]     rg2,
  input  logic [AW-1:0]        address,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out,
  output logic [3:0]           flags,
  output logic                 illegal,
  output logic                 busy
);

  localparam int DEPTH = 2**AW;
  localparam int CW    = $clog2(WIDTH);

  localparam logic [4:0] OP_ADD   = 5'b00000;
  localparam logic [4:0] OP_ADC   = 5'b00001;
  localparam logic [4:0] OP_SUB   = 5'b00010;
  localparam logic [4:0] OP_SBB   = 5'b00011;
  localparam logic [4:0] OP_MUL   = 5'b00100;
  localparam logic [4:0] OP_AND   = 5'b01000;
  localparam logic [4:0] OP_OR    = 5'b01001;
  localparam logic [4:0] OP_XOR   = 5'b01010;
  localparam logic [4:0] OP_NAND  = 5'b01011;
  localparam logic [4:0] OP_NOR   = 5'b01100;
  localparam logic [4:0] OP_XNOR  = 5'b01101;
  localparam logic [4:0] OP_NOT   = 5'b01110;
  localparam logic [4:0] OP_NEG   = 5'b01111;
  localparam logic [4:0] OP_LOAD  = 5'b10000;
  localparam logic [4:0] OP_STORE = 5'b11000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Signed overflow of a two's-complement add, judged from the sign bits of
  // both addends and of the sum. A carry-in cannot change the verdict.
  function automatic logic add_ovf(input logic sa, input logic sb, input logic sr);
    return (sa == sb) && (sr != sa);
  endfunction

  // Flag vector for a WIDTH-bit result with explicit carry and overflow.
  function automatic logic [3:0] mk_flags(input logic c, input logic [WIDTH-1:0] r, input logic v);
    return {c, (r == {WIDTH{1'b0}}), r[WIDTH-1], v};
  endfunction

  state_t                 state_r;
  logic [2*WIDTH-1:0]     out_r;
  logic [3:0]             flags_r;
  logic                   illegal_r;
  logic                   out_valid_r;
  logic [WIDTH-1:0]       mem_r [DEPTH];

  // Shift-add multiplier state
  logic [2*WIDTH-1:0]     mul_acc_r;
  logic [2*WIDTH-1:0]     mul_mcand_r;
  logic [WIDTH-1:0]       mul_mplier_r;
  logic [CW-1:0]          mul_cnt_r;
  logic [2*WIDTH-1:0]     mul_acc_nxt_s;

  // Decode and adder operand selection
  logic [WIDTH-1:0]       add_a_s;
  logic [WIDTH-1:0]       add_b_s;
  logic                   add_cin_s;
  logic [WIDTH:0]         add_sum_s;
  logic                   add_ovf_s;
  logic [WIDTH-1:0]       arith_lo_s;
  logic                   arith_c_s;
  logic [WIDTH-1:0]       logic_res_s;
  logic                   is_arith_s;
  logic                   is_logic_s;
  logic                   is_mul_s;
  logic                   is_load_s;
  logic                   is_store_s;
  logic                   is_illegal_s;

  // Result and flags to register for a single-cycle operation
  logic [2*WIDTH-1:0]     res_s;
  logic [3:0]             flags_nxt_s;

  // Opcode decode: classify the op and set up adder operands and logic result.
  always_comb begin
    add_a_s      = rg1;
    add_b_s      = rg2;
    add_cin_s    = 1'b0;
    logic_res_s  = {WIDTH{1'b0}};
    is_arith_s   = 1'b0;
    is_logic_s   = 1'b0;
    is_mul_s     = 1'b0;
    is_load_s    = 1'b0;
    is_store_s   = 1'b0;
    is_illegal_s = 1'b0;
    case (opcode)
      OP_ADD: begin
        is_arith_s = 1'b1;
      end
      OP_ADC: begin
        is_arith_s = 1'b1;
        add_cin_s  = flags_r[3];
      end
      OP_SUB: begin
        is_arith_s = 1'b1;
        add_b_s    = ~rg2;
        add_cin_s  = 1'b1;
      end
      OP_SBB: begin
        // stored C = 1 means "no borrow"
        is_arith_s = 1'b1;
        add_b_s    = ~rg2;
        add_cin_s  = flags_r[3];
      end
      OP_NEG: begin
        // ~rg1 + 0 + 1: carry out is set exactly when rg1 == 0
        is_arith_s = 1'b1;
        add_a_s    = ~rg1;
        add_b_s    = {WIDTH{1'b0}};
        add_cin_s  = 1'b1;
      end
      OP_MUL: begin
        is_mul_s = 1'b1;
      end
      OP_AND: begin
        is_logic_s  = 1'b1;
        logic_res_s = rg1 & rg2;
      end
      OP_OR: begin
        is_logic_s  = 1'b1;
        logic_res_s = rg1 | rg2;
      end
      OP_XOR: begin
        is_logic_s  = 1'b1;
        logic_res_s = rg1 ^ rg2;
      end
      OP_NAND: begin
        is_logic_s  = 1'b1;
        logic_res_s = ~(rg1 & rg2);
      end
      OP_NOR: begin
        is_logic_s  = 1'b1;
        logic_res_s = ~(rg1 | rg2);
      end
      OP_XNOR: begin
        is_logic_s  = 1'b1;
        logic_res_s = ~(rg1 ^ rg2);
      end
      OP_NOT: begin
        is_logic_s  = 1'b1;
        logic_res_s = ~rg1;
      end
      OP_LOAD: begin
        is_load_s = 1'b1;
      end
      OP_STORE: begin
        is_store_s = 1'b1;
      end
      default: begin
        is_illegal_s = 1'b1;
      end
    endcase
  end

  // Shared adder for every add/subtract/negate variant.
  assign add_sum_s = {1'b0, add_a_s} + {1'b0, add_b_s} + {{WIDTH{1'b0}}, add_cin_s};
  assign add_ovf_s = add_ovf(add_a_s[WIDTH-1], add_b_s[WIDTH-1], add_sum_s[WIDTH-1]);

`ifdef ALU_MC_SAT_EN
  // Saturating arithmetic: on overflow both addends share a sign, and that
  // sign selects the clamp direction.
  always_comb begin
    if (add_ovf_s) begin
      if (add_a_s[WIDTH-1]) begin
        arith_lo_s = {1'b1, {(WIDTH-1){1'b0}}};
      end else begin
        arith_lo_s = {1'b0, {(WIDTH-1){1'b1}}};
      end
      arith_c_s = 1'b0;
    end else begin
      arith_lo_s = add_sum_s[WIDTH-1:0];
      arith_c_s  = add_sum_s[WIDTH];
    end
  end
`else
  // Wrapping arithmetic: the adder output is used as-is.
  always_comb begin
    arith_lo_s = add_sum_s[WIDTH-1:0];
    arith_c_s  = add_sum_s[WIDTH];
  end
`endif

  // Result and next flags for everything that completes at accept.
  always_comb begin
    res_s       = {(2*WIDTH){1'b0}};
    flags_nxt_s = flags_r;
    if (is_arith_s) begin
      res_s       = {{(WIDTH-1){1'b0}}, arith_c_s, arith_lo_s};
      flags_nxt_s = mk_flags(arith_c_s, arith_lo_s, add_ovf_s);
    end else if (is_logic_s) begin
      res_s       = {{WIDTH{1'b0}}, logic_res_s};
      flags_nxt_s = mk_flags(1'b0, logic_res_s, 1'b0);
    end else if (is_load_s) begin
      res_s       = {{WIDTH{1'b0}}, mem_r[address]};
      flags_nxt_s = flags_r;
    end else begin
      // STORE, illegal (and MUL, which never uses this path): out = 0
      res_s       = {(2*WIDTH){1'b0}};
      flags_nxt_s = flags_r;
    end
  end

  // Accumulator value after adding this cycle's partial product.
  assign mul_acc_nxt_s = mul_acc_r + (mul_mplier_r[0] ? mul_mcand_r : {(2*WIDTH){1'b0}});

  // Control FSM, result/flag registers, multiplier datapath and scratch memory.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      out_r        <= {(2*WIDTH){1'b0}};
      flags_r      <= 4'b0000;
      illegal_r    <= 1'b0;
      out_valid_r  <= 1'b0;
      mul_acc_r    <= {(2*WIDTH){1'b0}};
      mul_mcand_r  <= {(2*WIDTH){1'b0}};
      mul_mplier_r <= {WIDTH{1'b0}};
      mul_cnt_r    <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= WIDTH'(i);
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            if (is_mul_s) begin
              mul_acc_r    <= {(2*WIDTH){1'b0}};
              mul_mcand_r  <= {{WIDTH{1'b0}}, rg1};
              mul_mplier_r <= rg2;
              mul_cnt_r    <= {CW{1'b0}};
              state_r      <= ST_MUL;
            end else begin
              out_r       <= res_s;
              flags_r     <= flags_nxt_s;
              illegal_r   <= is_illegal_s;
              out_valid_r <= 1'b1;
              state_r     <= ST_DONE;
              if (is_store_s) begin
                mem_r[address] <= rg1;
              end
            end
          end
        end
        ST_MUL: begin
          mul_acc_r    <= mul_acc_nxt_s;
          mul_mcand_r  <= {mul_mcand_r[2*WIDTH-2:0], 1'b0};
          mul_mplier_r <= {1'b0, mul_mplier_r[WIDTH-1:1]};
          mul_cnt_r    <= mul_cnt_r + CW'(1);
          // last of WIDTH partial products: publish the full product
          if (mul_cnt_r == CW'(WIDTH-1)) begin
            out_r       <= mul_acc_nxt_s;
            flags_r     <= {1'b0, (mul_acc_nxt_s == {(2*WIDTH){1'b0}}),
                            mul_acc_nxt_s[2*WIDTH-1], 1'b0};
            illegal_r   <= 1'b0;
            out_valid_r <= 1'b1;
            state_r     <= ST_DONE;
          end
        end
        ST_DONE: begin
          // out/flags/illegal hold until the consumer takes the result
          if (out_ready) begin
            out_valid_r <= 1'b0;
            state_r     <= ST_IDLE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state_r == ST_IDLE);
  assign busy      = (state_r != ST_IDLE);
  assign out_valid = out_valid_r;
  assign out       = out_r;
  assign flags     = flags_r;
  assign illegal   = illegal_r;

endmodule

// File: tb/tb_alu_mc_core.sv
// ---------------------------------------------------------------------------
// tb_alu_mc_core
//
// Self-checking bench for alu_mc_core (WIDTH=32, AW=5). Directed cases cover
// reset state, carry chaining, MUL latency, output back-pressure, memory
// and illegal opcodes, and reset in the middle of a MUL; a randomized
// stream is checked against an arithmetic reference model of the flags and
// scratch memory.
// ---------------------------------------------------------------------------
module tb_alu_mc_core;

  localparam int W  = 32;
  localparam int AW = 5;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      opcode;
  logic [W-1:0]    rg1;
  logic [W-1:0]    rg2;
  logic [AW-1:0]   address;
  logic            out_valid;
  logic            out_ready;
  logic [2*W-1:0]  out;
  logic [3:0]      flags;
  logic            illegal;
  logic            busy;

  int vectors    = 0;
  int miscompares = 0;

  // reference model state
  logic [3:0]      m_flags;
  logic [W-1:0]    m_mem [32];

  alu_mc_core #(.WIDTH(W), .AW(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .rg1       (rg1),
    .rg2       (rg2),
    .address   (address),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .flags     (flags),
    .illegal   (illegal),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_flags = 4'b0000;
    for (int i = 0; i < 32; i++) m_mem[i] = 32'(i);
  endtask

  // Reference behaviour computed with plain integer arithmetic.
  task automatic model_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] ad, output logic [63:0] eo, output logic [3:0] ef,
                          output logic eil, output int elat);
    logic [63:0] ua, ub, full, mask;
    longint sa, sb, ideal;
    logic [31:0] res;
    logic c, ovf, is_ar;
    int cin;
    ua = {32'h0, a}; ub = {32'h0, b}; mask = 64'h0000_0000_FFFF_FFFF;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    cin = int'(m_flags[3]);
    eo = 64'h0; ef = m_flags; eil = 1'b0; elat = 1; is_ar = 1'b0;
    full = 64'h0; ideal = 0; res = 32'h0;
    case (op)
      5'b00000: begin full = ua + ub;                      ideal = sa + sb;           is_ar = 1'b1; end
      5'b00001: begin full = ua + ub + 64'(cin);           ideal = sa + sb + cin;     is_ar = 1'b1; end
      5'b00010: begin full = ua + (mask - ub) + 64'd1;     ideal = sa - sb;           is_ar = 1'b1; end
      5'b00011: begin full = ua + (mask - ub) + 64'(cin);  ideal = sa - sb - 1 + cin; is_ar = 1'b1; end
      5'b01111: begin full = (mask - ua) + 64'd1;          ideal = -sa;               is_ar = 1'b1; end
      5'b00100: begin
        eo = ua * ub; elat = 33;
        ef = {1'b0, eo == 64'h0, eo[63], 1'b0};
      end
      5'b01000, 5'b01001, 5'b01010, 5'b01011, 5'b01100, 5'b01101, 5'b01110: begin
        case (op)
          5'b01000: res = a & b;
          5'b01001: res = a | b;
          5'b01010: res = a ^ b;
          5'b01011: res = ~(a & b);
          5'b01100: res = ~(a | b);
          5'b01101: res = ~(a ^ b);
          default:  res = ~a;
        endcase
        eo = {32'h0, res};
        ef = {1'b0, res == 32'h0, res[31], 1'b0};
      end
      5'b10000: eo = {32'h0, m_mem[ad]};
      5'b11000: begin m_mem[ad] = a; eo = 64'h0; end
      default:  begin eil = 1'b1; eo = 64'h0; end
    endcase
    if (is_ar) begin
      res = full[31:0];
      c   = full[32];
      ovf = (ideal > 64'sd2147483647) || (ideal < -64'sd2147483648);
`ifdef ALU_MC_SAT_EN
      if (ovf) begin
        res = (ideal > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
        c   = 1'b0;
      end
`endif
      eo = {31'h0, c, res};
      ef = {c, res == 32'h0, res[31], ovf};
    end
    m_flags = ef;
  endtask

  // One full transaction: accept, wait for result, optional back-pressure, pop.
  task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] ad, input int hold,
                        output logic [63:0] o, output logic [3:0] f, output logic il);
    logic [63:0] eo;
    logic [3:0]  ef;
    logic        eil, stable;
    int          elat, lat, g;
    model_op(op, a, b, ad, eo, ef, eil, elat);
    @(negedge clk);
    opcode = op; rg1 = a; rg2 = b; address = ad; in_valid = 1'b1; out_ready = 1'b0;
    g = 0;
    while (!in_ready && g < 50) begin @(negedge clk); g++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    rg1 = $urandom; rg2 = $urandom; opcode = 5'($urandom); address = 5'($urandom);
    lat = 1;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    o = out; f = flags; il = illegal;
    check({tag, ".lat"}, 64'(lat), 64'(elat));
    check({tag, ".out"}, o, eo);
    check({tag, ".flags"}, 64'(f), 64'(ef));
    check({tag, ".illegal"}, 64'(il), 64'(eil));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      stable = (out === o) && (flags === f) && (illegal === il) && out_valid && !in_ready;
      check({tag, ".hold"}, 64'(stable), 64'd1);
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    check({tag, ".idle"}, 64'({out_valid, in_ready, busy}), 64'(3'b010));
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [63:0] o;
    logic [3:0]  f;
    logic        il, seen;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    opcode = 5'b00000; rg1 = 32'h0; rg2 = 32'h0; address = 5'h0;
    model_reset();
    #8;
    check("rst.out", out, 64'h0);
    check("rst.ctl", 64'({out_valid, illegal, busy}), 64'(3'b000));
    check("rst.flags", 64'(flags), 64'h0);
    @(negedge clk); rst_n = 1'b1;
    #1 check("rst.in_ready", 64'(in_ready), 64'd1);

    run_op("load7", 5'b10000, 32'h0, 32'h0, 5'd7, 0, o, f, il);
    check("load7.const", o, 64'd7);
    check("load7.flags_const", 64'(f), 64'h0);

    run_op("add_c", 5'b00000, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0, 0, o, f, il);
    check("add_c.const", o, 64'h0000_0001_0000_0000);
    check("add_c.flags_const", 64'(f), 64'(4'b1100));

    run_op("adc", 5'b00001, 32'd5, 32'd3, 5'd0, 0, o, f, il);
    check("adc.const", o, 64'd9);
    check("adc.c_const", 64'(f[3]), 64'd0);

    run_op("mul", 5'b00100, 32'h0001_0000, 32'h0003_0000, 5'd0, 0, o, f, il);
    check("mul.const", o, 64'h0000_0003_0000_0000);

    run_op("sub_hold", 5'b00010, 32'd3, 32'd5, 5'd0, 5, o, f, il);
    check("sub_hold.const", 64'(o[31:0]), 64'h0000_0000_FFFF_FFFE);
    check("sub_hold.nc", 64'({f[1], f[3]}), 64'(2'b10));

    run_op("store31", 5'b11000, 32'hDEAD_BEEF, 32'h0, 5'd31, 0, o, f, il);
    check("store31.const", o, 64'h0);
    run_op("load31", 5'b10000, 32'h0, 32'h0, 5'd31, 0, o, f, il);
    check("load31.const", o, 64'h0000_0000_DEAD_BEEF);

    run_op("ill", 5'b00101, 32'h1234_5678, 32'h9, 5'd0, 2, o, f, il);
    check("ill.const", 64'({il, f}), 64'({1'b1, 4'b0010}));

    run_op("ovf", 5'b00000, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0, 0, o, f, il);
`ifdef ALU_MC_SAT_EN
    check("ovf.const", o, 64'h0000_0000_7FFF_FFFF);
    check("ovf.flags_const", 64'(f), 64'(4'b0001));
`else
    check("ovf.const", o, 64'h0000_0000_8000_0000);
    check("ovf.flags_const", 64'(f), 64'(4'b0011));
`endif

    for (int n = 0; n < 120; n++) begin
      logic [4:0] rop;
      rop = 5'($urandom);
      if ($urandom_range(0, 3) == 0) rop = 5'($urandom_range(0, 3));
      run_op("rand", rop, pick_operand(), pick_operand(), 5'($urandom),
             int'($urandom_range(0, 2)), o, f, il);
    end

    // reset in the middle of a MUL: the operation must vanish
    @(negedge clk);
    opcode = 5'b00100; rg1 = 32'h0000_0123; rg2 = 32'h0000_0456; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rstmul.async", 64'({out_valid, busy, flags}), 64'h0);
    @(negedge clk); rst_n = 1'b1;
    model_reset();
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("rstmul.novalid", 64'(seen), 64'd0);
    check("rstmul.in_ready", 64'(in_ready), 64'd1);
    check("rstmul.flags", 64'(flags), 64'h0);
    run_op("rstmem", 5'b10000, 32'h0, 32'h0, 5'd31, 0, o, f, il);
    check("rstmem.const", o, 64'd31);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
